// File: rtl/cpu_pkg.sv
// Shared CPU definitions: ALU opcodes, instruction field layout and issue-slot type.
package cpu_pkg;

   localparam int IMM_W_DEF = 14;
   localparam int XLEN      = 32;

   typedef logic [2:0] alu_op_t;

   localparam alu_op_t OP_NOOP0 = 3'b000;
   localparam alu_op_t OP_NOOP1 = 3'b001;
   localparam alu_op_t OP_ADD   = 3'b010;
   localparam alu_op_t OP_SUB   = 3'b011;
   localparam alu_op_t OP_SHL   = 3'b100;
   localparam alu_op_t OP_SHR   = 3'b101;
   localparam alu_op_t OP_ADDI  = 3'b110;
   localparam alu_op_t OP_SUBI  = 3'b111;

   localparam int OP_MSB = 31;
   localparam int OP_LSB = 29;
   localparam int RD_MSB = 28;
   localparam int RD_LSB = 24;
   localparam int RS_MSB = 23;
   localparam int RS_LSB = 19;
   localparam int RT_MSB = 18;
   localparam int RT_LSB = 14;

   typedef struct packed {
      alu_op_t           op;
      logic [XLEN-1:0]   a;
      logic [XLEN-1:0]   b;
      logic [4:0]        rd;
   } slot_t;

endpackage

// File: rtl/operand_fwd_mux.sv
// Source-operand select: register 0 reads as zero, a same-cycle writeback wins over the register file.
module operand_fwd_mux
   import cpu_pkg::*;
(
   input  logic [4:0]      src_addr,
   input  logic [XLEN-1:0] rf_data,
   input  logic            wb_valid,
   input  logic [4:0]      wb_addr,
   input  logic [XLEN-1:0] wb_data,
   output logic [XLEN-1:0] src_val
);

   always_comb begin
      if (src_addr == 5'd0) begin
         src_val = '0;
      end else if (wb_valid && (wb_addr == src_addr)) begin
         src_val = wb_data;
      end else begin
         src_val = rf_data;
      end
   end

endmodule

// File: rtl/alu_issue_stage.sv
// Operand-issue stage ahead of the ALU: reads and forwards sources, forms operands,
// and holds them in one registered slot with valid/ready on both sides.
module alu_issue_stage
   import cpu_pkg::*;
#(
   parameter int CNT_W = 16,
   parameter int IMM_W = IMM_W_DEF
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [31:0]      in_instr,
   output logic [4:0]       rs_addr,
   output logic [4:0]       rt_addr,
   input  logic [31:0]      rs_data,
   input  logic [31:0]      rt_data,
   input  logic             wb_valid,
   input  logic [4:0]       wb_addr,
   input  logic [31:0]      wb_data,
   input  logic             flush,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [2:0]       out_aluop,
   output logic [31:0]      out_a,
   output logic [31:0]      out_b,
   output logic [4:0]       out_rd,
   output logic [CNT_W-1:0] issue_count,
   output logic [CNT_W-1:0] stall_count
);

   logic             valid_q, valid_d;
   slot_t            slot_q, slot_d;
   logic [CNT_W-1:0] issue_q, issue_d;
   logic [CNT_W-1:0] stall_q, stall_d;

   alu_op_t     op;
   logic [4:0]  rd_field;
   logic [31:0] rs_val, rt_val, imm_ext;
   slot_t       new_slot;
   logic        accept, fire;

   assign op       = in_instr[OP_MSB:OP_LSB];
   assign rd_field = in_instr[RD_MSB:RD_LSB];
   assign rs_addr  = in_instr[RS_MSB:RS_LSB];
   assign rt_addr  = in_instr[RT_MSB:RT_LSB];
   assign imm_ext  = {{(XLEN-IMM_W){in_instr[IMM_W-1]}}, in_instr[IMM_W-1:0]};

   operand_fwd_mux u_fwd_rs (
      .src_addr (rs_addr),
      .rf_data  (rs_data),
      .wb_valid (wb_valid),
      .wb_addr  (wb_addr),
      .wb_data  (wb_data),
      .src_val  (rs_val)
   );

   operand_fwd_mux u_fwd_rt (
      .src_addr (rt_addr),
      .rf_data  (rt_data),
      .wb_valid (wb_valid),
      .wb_addr  (wb_addr),
      .wb_data  (wb_data),
      .src_val  (rt_val)
   );

   assign in_ready = !flush && (!valid_q || out_ready);
   assign accept   = in_valid && in_ready;
   assign fire     = valid_q && out_ready;

   always_comb begin
      // NOTE: every output of a combinational block gets a default first so no path leaves it unassigned (no latch).
      new_slot    = '0;
      new_slot.op = op;
      unique case (op)
         OP_NOOP0, OP_NOOP1: ;
         OP_ADD, OP_SUB, OP_SHL, OP_SHR: begin
            new_slot.a  = rs_val;
            new_slot.b  = rt_val;
            new_slot.rd = rd_field;
         end
         default: begin
            new_slot.a  = rs_val;
            new_slot.b  = imm_ext;
            new_slot.rd = rd_field;
         end
      endcase
   end

   always_comb begin
      valid_d = valid_q;
      slot_d  = slot_q;
      issue_d = issue_q;
      stall_d = stall_q;

      // A flush drops the held slot but a same-cycle fire was already taken downstream.
      if (flush) begin
         valid_d = 1'b0;
      end else if (accept) begin
         valid_d = 1'b1;
         slot_d  = new_slot;
      end else if (fire) begin
         valid_d = 1'b0;
      end

      if (fire) begin
         issue_d = issue_q + CNT_W'(1);
      end
      if (valid_q && !out_ready && (stall_q != '1)) begin
         stall_d = stall_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
      if (rst) begin
         valid_q <= 1'b0;
         slot_q  <= '0;
         issue_q <= '0;
         stall_q <= '0;
      end else begin
         valid_q <= valid_d;
         slot_q  <= slot_d;
         issue_q <= issue_d;
         stall_q <= stall_d;
      end
   end

   assign out_valid   = valid_q;
   assign out_aluop   = slot_q.op;
   assign out_a       = slot_q.a;
   assign out_b       = slot_q.b;
   assign out_rd      = slot_q.rd;
   assign issue_count = issue_q;
   assign stall_count = stall_q;

endmodule

// File: tb/tb_alu_issue_stage.sv
// Directed bench for alu_issue_stage; counters run at 8 bits so wrap and saturation fit in a short run.
module tb_alu_issue_stage;

   localparam int CNT_W = 8;

   logic             clk = 1'b0;
   logic             rst;
   logic             in_valid;
   logic             in_ready;
   logic [31:0]      in_instr;
   logic [4:0]       rs_addr, rt_addr;
   logic [31:0]      rs_data, rt_data;
   logic             wb_valid;
   logic [4:0]       wb_addr;
   logic [31:0]      wb_data;
   logic             flush;
   logic             out_valid;
   logic             out_ready;
   logic [2:0]       out_aluop;
   logic [31:0]      out_a, out_b;
   logic [4:0]       out_rd;
   logic [CNT_W-1:0] issue_count, stall_count;

   int total = 0;
   int bad   = 0;
   int exp_issue;
   int nwrap;

   always #5 clk = ~clk;

   alu_issue_stage #(.CNT_W(CNT_W), .IMM_W(14)) dut (
      .clk         (clk),
      .rst         (rst),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .in_instr    (in_instr),
      .rs_addr     (rs_addr),
      .rt_addr     (rt_addr),
      .rs_data     (rs_data),
      .rt_data     (rt_data),
      .wb_valid    (wb_valid),
      .wb_addr     (wb_addr),
      .wb_data     (wb_data),
      .flush       (flush),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .out_aluop   (out_aluop),
      .out_a       (out_a),
      .out_b       (out_b),
      .out_rd      (out_rd),
      .issue_count (issue_count),
      .stall_count (stall_count)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] mk(input logic [2:0] op, input logic [4:0] rd,
                                      input logic [4:0] rs, input logic [4:0] rt,
                                      input logic [13:0] imm);
      return {op, rd, rs, rt, imm};
   endfunction

   // Drive inputs, let them settle, then sit 1 time unit after the next rising edge.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic issue(input logic [31:0] instr, input logic [31:0] rsd, input logic [31:0] rtd,
                        input logic wbv, input logic [4:0] wba, input logic [31:0] wbd);
      in_valid = 1'b1;
      in_instr = instr;
      rs_data  = rsd;
      rt_data  = rtd;
      wb_valid = wbv;
      wb_addr  = wba;
      wb_data  = wbd;
      step();
      in_valid = 1'b0;
      wb_valid = 1'b0;
      in_instr = 32'h0;
   endtask

   initial begin
      rst = 1'b1; in_valid = 0; in_instr = 0; rs_data = 0; rt_data = 0;
      wb_valid = 0; wb_addr = 0; wb_data = 0; flush = 0; out_ready = 0;
      step(); step();
      rst = 1'b0;
      #1;
      check("rst_valid", {31'b0, out_valid}, 0);
      check("rst_a", out_a, 0);
      check("rst_issue", {24'b0, issue_count}, 0);
      check("rst_stall", {24'b0, stall_count}, 0);

      // ADD rd=3 rs=1 rt=2
      out_ready = 1'b1;
      in_instr  = mk(3'b010, 5'd3, 5'd1, 5'd2, 14'h0);
      #1;
      check("rs_addr", {27'b0, rs_addr}, 1);
      check("rt_addr", {27'b0, rt_addr}, 2);
      check("in_ready_idle", {31'b0, in_ready}, 1);
      issue(mk(3'b010, 5'd3, 5'd1, 5'd2, 14'h0), 32'd5, 32'd7, 1'b0, 5'd0, 32'd0);
      check("add_valid", {31'b0, out_valid}, 1);
      check("add_op", {29'b0, out_aluop}, 3'b010);
      check("add_a", out_a, 5);
      check("add_b", out_b, 7);
      check("add_rd", {27'b0, out_rd}, 3);
      check("add_issue_pre", {24'b0, issue_count}, 0);
      step();
      check("add_drained", {31'b0, out_valid}, 0);
      check("add_issue", {24'b0, issue_count}, 1);

      // ADDI negative imm; rt field names a register under writeback but must be ignored
      issue(mk(3'b110, 5'd5, 5'd4, 5'd9, 14'h3FFF), 32'd10, 32'h1234, 1'b1, 5'd9, 32'hDEAD);
      check("addi_neg_a", out_a, 10);
      check("addi_neg_b", out_b, 32'hFFFF_FFFF);
      check("addi_neg_rd", {27'b0, out_rd}, 5);
      issue(mk(3'b111, 5'd6, 5'd4, 5'd0, 14'h0005), 32'd10, 32'd0, 1'b0, 5'd0, 32'd0);
      check("subi_pos_op", {29'b0, out_aluop}, 3'b111);
      check("subi_pos_b", out_b, 5);
      check("issue_back_to_back", {24'b0, issue_count}, 2);

      // SUB with forwarding of rs; rt=0 reads zero regardless of rt_data
      issue(mk(3'b011, 5'd1, 5'd3, 5'd0, 14'h0), 32'h11, 32'h55, 1'b1, 5'd3, 32'hAB);
      check("fwd_a", out_a, 32'hAB);
      check("fwd_rt0_b", out_b, 0);
      issue(mk(3'b011, 5'd1, 5'd0, 5'd2, 14'h0), 32'h99, 32'h22, 1'b1, 5'd0, 32'h77);
      check("r0_a", out_a, 0);
      check("r0_b", out_b, 32'h22);

      // NOOP forces operands and rd to zero but keeps the opcode
      issue(mk(3'b001, 5'd7, 5'd1, 5'd2, 14'h1F), 32'h33, 32'h44, 1'b0, 5'd0, 32'd0);
      check("noop_op", {29'b0, out_aluop}, 3'b001);
      check("noop_a", out_a, 0);
      check("noop_b", out_b, 0);
      check("noop_rd", {27'b0, out_rd}, 0);
      exp_issue = 5;

      // Backpressure: SHR held for 4 cycles while writeback hits its source
      issue(mk(3'b101, 5'd2, 5'd1, 5'd2, 14'h0), 32'h100, 32'h3, 1'b0, 5'd0, 32'd0);
      exp_issue++;
      check("hold_issue_start", {24'b0, issue_count}, exp_issue);
      out_ready = 1'b0;
      in_valid  = 1'b1;
      in_instr  = mk(3'b100, 5'd4, 5'd6, 5'd7, 14'h0);
      rs_data   = 32'h8;
      rt_data   = 32'h2;
      wb_valid  = 1'b1;
      wb_addr   = 5'd1;
      wb_data   = 32'hFACE;
      #1;
      check("stall_in_ready", {31'b0, in_ready}, 0);
      repeat (4) step();
      check("hold_valid", {31'b0, out_valid}, 1);
      check("hold_op", {29'b0, out_aluop}, 3'b101);
      check("hold_a", out_a, 32'h100);
      check("hold_b", out_b, 32'h3);
      check("stall_4", {24'b0, stall_count}, 4);
      wb_valid  = 1'b0;
      out_ready = 1'b1;
      #1;
      check("release_in_ready", {31'b0, in_ready}, 1);
      step();
      in_valid = 1'b0;
      exp_issue++;
      check("release_issue", {24'b0, issue_count}, exp_issue);
      check("release_op", {29'b0, out_aluop}, 3'b100);
      check("release_a", out_a, 32'h8);
      check("release_b", out_b, 32'h2);
      check("stall_kept", {24'b0, stall_count}, 4);

      // Flush while SHL is held: dropped, not counted, new instruction ignored
      out_ready = 1'b0;
      flush     = 1'b1;
      in_valid  = 1'b1;
      in_instr  = mk(3'b010, 5'd9, 5'd1, 5'd1, 14'h0);
      #1;
      check("flush_in_ready", {31'b0, in_ready}, 0);
      step();
      flush    = 1'b0;
      in_valid = 1'b0;
      check("flush_valid", {31'b0, out_valid}, 0);
      check("flush_issue", {24'b0, issue_count}, exp_issue);
      check("flush_stall", {24'b0, stall_count}, 5);
      step();
      check("flush_no_capture", {31'b0, out_valid}, 0);

      // Flush coinciding with a fire still counts the issue
      out_ready = 1'b1;
      issue(mk(3'b010, 5'd1, 5'd1, 5'd1, 14'h0), 32'd1, 32'd1, 1'b0, 5'd0, 32'd0);
      flush = 1'b1;
      step();
      flush = 1'b0;
      exp_issue++;
      check("flush_fire_issue", {24'b0, issue_count}, exp_issue);
      check("flush_fire_valid", {31'b0, out_valid}, 0);

      // Back-to-back stream until the issue counter wraps past 2^CNT_W to 2
      nwrap    = (1 << CNT_W) + 2 - exp_issue;
      in_valid = 1'b1;
      in_instr = mk(3'b010, 5'd1, 5'd2, 5'd3, 14'h0);
      repeat (nwrap) step();
      in_valid = 1'b0;
      step();
      check("issue_wrap", {24'b0, issue_count}, 2);

      // Long stall saturates the stall counter
      issue(mk(3'b010, 5'd1, 5'd2, 5'd3, 14'h0), 32'd0, 32'd0, 1'b0, 5'd0, 32'd0);
      out_ready = 1'b0;
      repeat (300) step();
      check("stall_sat", {24'b0, stall_count}, 32'hFF);
      step();
      check("stall_sat_hold", {24'b0, stall_count}, 32'hFF);

      // Reset overrides flush and handshake
      rst      = 1'b1;
      flush    = 1'b1;
      in_valid = 1'b1;
      step();
      rst = 1'b0; flush = 1'b0; in_valid = 1'b0;
      check("rst2_valid", {31'b0, out_valid}, 0);
      check("rst2_op", {29'b0, out_aluop}, 0);
      check("rst2_rd", {27'b0, out_rd}, 0);
      check("rst2_issue", {24'b0, issue_count}, 0);
      check("rst2_stall", {24'b0, stall_count}, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/alu_issue_stage.md
Name: alu_issue_stage

Overview:
- Operand-issue stage directly upstream of the CPU ALU: accepts one decoded 32-bit instruction per cycle, reads source registers, applies writeback forwarding, forms the ALU operands and holds them in a single registered slot.
- The ALU consumes out_aluop/out_a/out_b combinationally. The writeback stage consumes the ALU result together with out_rd.
- Valid/ready handshakes on both sides. Flush input for branch redirect. Two performance counters.

Parameters:
- CNT_W, 16, width of the issue and stall counters.
- IMM_W, 14, immediate field width; sign-extended to 32 bits.

Ports:
- clk  in  1  clock; all state updates on the rising edge
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  decoded instruction present
- in_ready  out  1  stage can accept this cycle
- in_instr  in  32  [31:29] op, [28:24] rd, [23:19] rs, [18:14] rt, [13:0] imm
- rs_addr  out  5  register-file read address A (combinational = in_instr[23:19])
- rt_addr  out  5  register-file read address B (combinational = in_instr[18:14])
- rs_data  in  32  async read data for rs_addr
- rt_data  in  32  async read data for rt_addr
- wb_valid  in  1  writeback occurring this cycle
- wb_addr  in  5  writeback destination
- wb_data  in  32  writeback value
- flush  in  1  discard the held instruction and block acceptance this cycle
- out_valid  out  1  issue slot occupied
- out_ready  in  1  downstream accepts this cycle
- out_aluop  out  3  ALU opcode
- out_a  out  32  ALU operand A
- out_b  out  32  ALU operand B
- out_rd  out  5  destination register; 0 means no write
- issue_count  out  CNT_W  instructions issued (wrapping)
- stall_count  out  CNT_W  backpressure cycles (saturating)

Behaviour:
- Reset: out_valid=0, out_aluop=0, out_a=0, out_b=0, out_rd=0, issue_count=0, stall_count=0. Reset overrides flush and any handshake.
- Handshakes:
  - in_ready = !flush && (!out_valid || out_ready). Combinational; it must not depend on in_valid.
  - Accept = in_valid && in_ready. Fire = out_valid && out_ready.
- Slot update, in priority order:
  - rst: clear.
  - flush: out_valid←0.
  - Accept: load slot, out_valid←1.
  - Fire without accept: out_valid←0.
  - Otherwise: hold all outputs stable.
- Latency: 1 cycle. An instruction accepted in cycle N is presented in cycle N+1. Full throughput when out_ready is held high.
- Operand read, per source s in {rs, rt}:
  - If s==0: value 0.
  - Else if wb_valid && wb_addr==s: wb_data.
  - Else: the register-file data.
- Forwarding is required because writeback of the slot's result coincides with acceptance of the next instruction.
- Operand formation by op:
  - 000, 001 (NOOP): a=0, b=0, rd forced to 0.
  - 010, 011 (ADD, SUB): a=rs value, b=rt value.
  - 100, 101 (SHIFTL, SHIFTR): a=rs value, b=rt value. No masking here; the ALU uses b[4:0].
  - 110, 111 (ADDI, SUBI): a=rs value, b=sign-extended imm. The rt field is ignored and must not be forwarded.
- out_aluop = op unchanged.
- issue_count: increments on each fire; wraps from 2^CNT_W-1 to 0.
- stall_count: increments each cycle with out_valid && !out_ready; saturates at 2^CNT_W-1.
- Flush cycle:
  - A fire in that cycle still counts; the downstream has taken the instruction.
  - The held instruction is otherwise dropped without counting.
  - Any in_valid that cycle is ignored.
- While holding (out_valid && !out_ready): later wb activity must not alter out_a/out_b. Operands are captured only at accept.

Decomposition:
- Shared package cpu_pkg:
  - ALU opcode constants OP_NOOP0/OP_NOOP1/OP_ADD/OP_SUB/OP_SHL/OP_SHR/OP_ADDI/OP_SUBI.
  - Instruction field bit positions.
  - IMM_W default.
- One natural sub-module: operand_fwd_mux, a combinational zero/forward/regfile select, instantiated twice.

Test Plan:
- Reset, then instr ADD rd=3 rs=1 rt=2 with rs_data=5, rt_data=7, out_ready=1 → next cycle out_valid=1, aluop=010, a=5, b=7, rd=3; issue_count=1 after fire.
- ADDI rs=4 with imm=0x3FFF, rs_data=10 → b=0xFFFFFFFF, a=10. Repeat with imm=0x0005 → b=5.
- Accept SUB rs=3 while wb_valid=1, wb_addr=3, wb_data=0xAB, rs_data=0x11 → a=0xAB. Repeat with rs=0 and wb_addr=0 → a=0.
- Hold out_ready=0 for 4 cycles with in_valid=1 → in_ready=0, outputs stable, stall_count=4. Raise out_ready → fire, then the next instruction is accepted the same cycle.
- Slot holds SHL with out_ready=0, assert flush with in_valid=1 → next cycle out_valid=0, issue_count unchanged, new instruction not captured.
- Preload via 2^16+2 back-to-back fires → issue_count wraps to 2. Hold a stall for 70000 cycles → stall_count=0xFFFF.
